sum_controller: RTL
===================

Name: sum_controller

Overview:
- Control FSM that sits directly upstream of the sum datapath.
- Accepts a start request and drives the datapath's ld_sum, ld_counter, en_sum and en_counter controls, plus a local datapath re-arm reset.
- Watches the datapath's done flag, captures its result, and presents that result on a valid/ready output handshake to the downstream consumer.

Parameters:
- DATA_W, 16, width of the datapath result and of out_data.
- TIMEOUT, 200, maximum RUN-state cycles before the watchdog fires (only used with WATCHDOG_EN).
- TMR_W, 8, width of the watchdog cycle counter; must satisfy TIMEOUT < 2**TMR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new sum; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- ld_sum  out  1  datapath sum clear.
- ld_counter  out  1  datapath counter clear.
- en_sum  out  1  datapath accumulate enable.
- en_counter  out  1  datapath counter increment enable.
- dp_rst_n  out  1  active-low re-arm reset to the datapath; low while rst is low or while in CLEAR.
- done  in  1  datapath completion flag; sticky until the datapath is reset.
- dp_result  in  DATA_W  datapath result register.
- out_valid  out  1  out_data holds a captured result.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  captured sum.
- err  out  1  watchdog timeout flag.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; busy, ld_sum, ld_counter, en_sum, en_counter, out_valid and err all 0; out_data 0; dp_rst_n 0.
- All outputs are Moore-decoded from registered state. There is no combinational path from any input to any output, except rst to dp_rst_n.
- IDLE: start=1 moves to CLEAR. No other input is observed.
- CLEAR (exactly 1 cycle): dp_rst_n=0, ld_sum=1, ld_counter=1. Next state is RUN. done is ignored in this state.
- RUN: en_sum=1, en_counter=1. Stays in RUN until done is sampled high, then moves to SETTLE.
- SETTLE (exactly 1 cycle): all enables are 0. dp_result is stable during this cycle. On the exit edge, out_data is loaded from dp_result. Next state is OUT.
- OUT: out_valid=1 and out_data is held constant. out_valid and out_ready high on the same edge moves to IDLE, and out_valid falls. out_data retains its value after the handshake.
- start is ignored in every state except IDLE, including on the OUT handshake edge.
- Latency: out_valid rises on the 104th rising edge after the edge that sampled start, for the standard 1..100 datapath.
  - CLEAR: 1 edge.
  - RUN: 102 edges, because done is registered and the controller samples it one edge later.
  - SETTLE: 1 edge.
- Reset mid-operation returns to IDLE immediately. Any captured result is discarded and out_data is cleared to 0.
- done held high from a previous run is harmless: the datapath is re-armed in CLEAR before RUN samples done.

Optional Feature:
- WATCHDOG_EN defined:
  - A TMR_W-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT before done is seen, the FSM moves to ERR: err=1, busy=1, all enables 0, out_valid 0.
  - ERR exits only on start=1, which goes to CLEAR and clears err in the same edge.
  - If done and timeout occur on the same edge, done wins.
- WATCHDOG_EN undefined: no counter and no ERR state; err is tied to 0.

Decomposition:
- Shared package sum_pkg holds the state enum (IDLE, CLEAR, RUN, SETTLE, OUT, ERR) and the DATA_W default of 16.
- No sub-module; the watchdog counter is inline in this block.

Test Plan:
- Reset, then one start pulse with out_ready=1 and the real datapath attached: out_valid rises 104 edges after start, out_data=5050 (0x13BA), busy falls one edge after the handshake.
- out_ready held 0 for 20 cycles in OUT: out_valid stays 1 and out_data stays 5050; raising out_ready completes the handshake on the next edge.
- start pulsed during RUN and again on the OUT handshake edge: no second run starts and ld_sum does not pulse again.
- Two back-to-back runs without a global reset: dp_rst_n pulses low for exactly 1 cycle each time, and the second out_data is again 5050.
- rst asserted at RUN cycle 50: all outputs reach reset values asynchronously; after release the FSM is in IDLE and out_data=0.
- WATCHDOG_EN with TIMEOUT=50: after start, err=1 at RUN cycle 50 and out_valid never rises; a new start clears err and enters CLEAR.

Source files
------------

// File: rtl/sum_pkg.sv
// sum_pkg: shared state encoding and default widths for the sum controller
package sum_pkg;

    localparam int SUM_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        OUT,
        ERR
    } state_t;

endpackage

// File: rtl/sum_controller.sv
// sum_controller: control FSM for the sum datapath with a valid/ready result port; WATCHDOG_EN adds a RUN timeout and ERR state
module sum_controller
    import sum_pkg::*;
#(
    parameter int DATA_W  = SUM_DATA_W,
    parameter int TIMEOUT = 200,
    parameter int TMR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              ld_sum,
    output logic              ld_counter,
    output logic              en_sum,
    output logic              en_counter,
    output logic              dp_rst_n,
    input  logic              done,
    input  logic [DATA_W-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    if (TIMEOUT >= (1 << TMR_W) || TIMEOUT < 1) begin : g_bad_timeout
        $error("sum_controller: TIMEOUT must be in 1 .. 2**TMR_W-1");
    end

    state_t state, next;

`ifdef WATCHDOG_EN
    logic [TMR_W-1:0] tmr;
    logic             timeout;

    assign timeout = tmr == TMR_W'(TIMEOUT - 1);

    // watchdog: cleared while entering RUN, counts every RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmr <= '0;
        else if (state == CLEAR) tmr <= '0;
        else if (state == RUN) tmr <= tmr + 1'b1;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= next;
    end

    // next state and Moore-decoded datapath controls
    always_comb begin
        next       = state;
        busy       = state != IDLE;
        ld_sum     = state == CLEAR;
        ld_counter = state == CLEAR;
        en_sum     = state == RUN;
        en_counter = state == RUN;
        out_valid  = state == OUT;
        err        = 1'b0;
        case (state)
            IDLE:    next = start ? CLEAR : IDLE;
            CLEAR:   next = RUN;
`ifdef WATCHDOG_EN
            RUN:     next = done ? SETTLE : (timeout ? ERR : RUN);
            ERR: begin
                next = start ? CLEAR : ERR;
                err  = 1'b1;
            end
`else
            RUN:     next = done ? SETTLE : RUN;
`endif
            SETTLE:  next = OUT;
            OUT:     next = out_ready ? IDLE : OUT;
            default: next = IDLE;
        endcase
    end

    // re-arm the datapath under global reset and for the single CLEAR cycle
    assign dp_rst_n = rst && state != CLEAR;

    // result capture on the SETTLE exit edge; held through and after OUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_data <= '0;
        else if (state == SETTLE) out_data <= dp_result;
    end

endmodule
